// File: rtl/logic_unit_arbiter_if.sv
// Bus bundle between the two ALU issue ports, the arbiter and the shared
// logic datapath. The slave modport is the arbiter's view; the master
// modport is the surrounding environment's view.
// Optional zero flag on the response is present when LU_ZERO_FLAG_EN is defined.
interface logic_unit_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] lu_a;
    logic [WIDTH-1:0] lu_b;
    logic [2:0]       lu_op;
    logic [WIDTH-1:0] lu_result;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_result;
    logic             resp_err;
`ifdef LU_ZERO_FLAG_EN
    logic             resp_zero;
`endif

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  lu_result, resp_ready,
        output req0_ready, req1_ready,
        output lu_a, lu_b, lu_op,
        output resp_valid, resp_id, resp_result, resp_err
`ifdef LU_ZERO_FLAG_EN
        , output resp_zero
`endif
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output lu_result, resp_ready,
        input  req0_ready, req1_ready,
        input  lu_a, lu_b, lu_op,
        input  resp_valid, resp_id, resp_result, resp_err
`ifdef LU_ZERO_FLAG_EN
        , input  resp_zero
`endif
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between two requesters.
// One operation in flight: grant, launch operands, wait SETTLE_CYCLES for the
// gates to settle, capture the result and hold it until the consumer takes it.
// Optional macro LU_ZERO_FLAG_EN adds a registered all-zero result flag.
module logic_unit_arbiter #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic                  clk,
    input logic                  reset,
    logic_unit_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_prio;
    logic [3:0]       r_cnt;
    logic             r_op_err;
    logic [WIDTH-1:0] r_lu_a;
    logic [WIDTH-1:0] r_lu_b;
    logic [2:0]       r_lu_op;
    logic             r_resp_valid;
    logic             r_resp_id;
    logic [WIDTH-1:0] r_resp_result;
    logic             r_resp_err;
`ifdef LU_ZERO_FLAG_EN
    logic             r_resp_zero;
`endif

    logic             w_grant0;
    logic             w_grant1;
    logic             w_grant;
    logic [WIDTH-1:0] w_capture;

    // Grant decode: a lone requester wins outright, a tie goes to the pointer.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == IDLE) begin
            w_grant0 = bus.req0_valid && (!bus.req1_valid || !r_prio);
            w_grant1 = bus.req1_valid && (!bus.req0_valid ||  r_prio);
        end
        w_grant   = w_grant0 || w_grant1;
        w_capture = r_op_err ? '0 : bus.lu_result;
    end

    // Next-state logic for the IDLE -> SETTLE -> RESP cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_state_next = SETTLE;
            SETTLE:  if (r_cnt == '0) w_state_next = RESP;
            RESP:    if (bus.resp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Launch, settle countdown, capture and response hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio        <= 1'b0;
            r_cnt         <= '0;
            r_op_err      <= 1'b0;
            r_lu_a        <= '0;
            r_lu_b        <= '0;
            r_lu_op       <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_id     <= 1'b0;
            r_resp_result <= '0;
            r_resp_err    <= 1'b0;
`ifdef LU_ZERO_FLAG_EN
            r_resp_zero   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_lu_a    <= w_grant1 ? bus.req1_a  : bus.req0_a;
                        r_lu_b    <= w_grant1 ? bus.req1_b  : bus.req0_b;
                        r_lu_op   <= w_grant1 ? bus.req1_op : bus.req0_op;
                        r_op_err  <= (w_grant1 ? bus.req1_op : bus.req0_op) > 3'd4;
                        r_resp_id <= w_grant1;
                        r_cnt     <= 4'(SETTLE_CYCLES - 1);
                        r_prio    <= ~w_grant1;
                    end
                end
                SETTLE: begin
                    if (r_cnt == '0) begin
                        r_resp_valid  <= 1'b1;
                        r_resp_result <= w_capture;
                        r_resp_err    <= r_op_err;
`ifdef LU_ZERO_FLAG_EN
                        r_resp_zero   <= (w_capture == '0);
`endif
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready  = w_grant0;
    assign bus.req1_ready  = w_grant1;
    assign bus.lu_a        = r_lu_a;
    assign bus.lu_b        = r_lu_b;
    assign bus.lu_op       = r_lu_op;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_id     = r_resp_id;
    assign bus.resp_result = r_resp_result;
    assign bus.resp_err    = r_resp_err;
`ifdef LU_ZERO_FLAG_EN
    assign bus.resp_zero   = r_resp_zero;
`endif
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: main instance at SETTLE_CYCLES=2,
// plus instances at 1 and 15 for the latency sweep.
module tb_logic_unit_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter_if #(.WIDTH(32)) if0 ();
    logic_unit_arbiter_if #(.WIDTH(32)) ifs1 ();
    logic_unit_arbiter_if #(.WIDTH(32)) ifs15 ();

    logic_unit_arbiter #(.WIDTH(32), .SETTLE_CYCLES(2))  u_dut   (.clk(clk), .reset(reset), .bus(if0));
    logic_unit_arbiter #(.WIDTH(32), .SETTLE_CYCLES(1))  u_dut1  (.clk(clk), .reset(reset), .bus(ifs1));
    logic_unit_arbiter #(.WIDTH(32), .SETTLE_CYCLES(15)) u_dut15 (.clk(clk), .reset(reset), .bus(ifs15));

    // Reference logic unit; reserved codes give a nonzero pattern so forcing is visible.
    function automatic logic [31:0] lu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0:    lu_f = a & b;
            3'd1:    lu_f = ~(a & b);
            3'd2:    lu_f = a | b;
            3'd3:    lu_f = ~(a | b);
            3'd4:    lu_f = a ^ b;
            default: lu_f = a ^ ~b;
        endcase
    endfunction

    assign if0.lu_result   = lu_f(if0.lu_a, if0.lu_b, if0.lu_op);
    assign ifs1.lu_result  = lu_f(ifs1.lu_a, ifs1.lu_b, ifs1.lu_op);
    assign ifs15.lu_result = lu_f(ifs15.lu_a, ifs15.lu_b, ifs15.lu_op);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        tests++; if (if0.lu_a !== 32'h0) begin fails++; $display("FAIL reset_lu_a got %h want 0", if0.lu_a); end
        tests++; if (if0.lu_b !== 32'h0) begin fails++; $display("FAIL reset_lu_b got %h want 0", if0.lu_b); end
        tests++; if (if0.lu_op !== 3'd0) begin fails++; $display("FAIL reset_lu_op got %0d want 0", if0.lu_op); end
        tests++; if (if0.resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", if0.resp_valid); end
        tests++; if (if0.resp_id !== 1'b0) begin fails++; $display("FAIL reset_resp_id got %b want 0", if0.resp_id); end
        tests++; if (if0.resp_result !== 32'h0) begin fails++; $display("FAIL reset_resp_result got %h want 0", if0.resp_result); end
        tests++; if (if0.resp_err !== 1'b0) begin fails++; $display("FAIL reset_resp_err got %b want 0", if0.resp_err); end
        tests++; if ({if0.req0_ready, if0.req1_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready got %b want 00", {if0.req0_ready, if0.req1_ready}); end
`ifdef LU_ZERO_FLAG_EN
        tests++; if (if0.resp_zero !== 1'b0) begin fails++; $display("FAIL reset_resp_zero got %b want 0", if0.resp_zero); end
`endif
    endtask

    task automatic test_single_and();
        int n;
        if0.req0_a = 32'hFFFF0000; if0.req0_b = 32'h0F0F0F0F; if0.req0_op = 3'd0;
        if0.req0_valid = 1'b1; if0.resp_ready = 1'b1;
        #1;
        tests++; if ({if0.req0_ready, if0.req1_ready} !== 2'b10) begin fails++; $display("FAIL and_grant got %b want 10", {if0.req0_ready, if0.req1_ready}); end
        tick();
        n = 1;
        if0.req0_valid = 1'b0;
        tests++; if (if0.lu_a !== 32'hFFFF0000 || if0.lu_b !== 32'h0F0F0F0F || if0.lu_op !== 3'd0) begin
            fails++; $display("FAIL and_launch got %h %h %0d want ffff0000 0f0f0f0f 0", if0.lu_a, if0.lu_b, if0.lu_op); end
        while (!if0.resp_valid && n < 20) begin tick(); n++; end
        tests++; if (n !== 3) begin fails++; $display("FAIL and_latency got %0d want 3", n); end
        tests++; if (if0.resp_result !== 32'h0F0F0000) begin fails++; $display("FAIL and_result got %h want 0f0f0000", if0.resp_result); end
        tests++; if (if0.resp_id !== 1'b0 || if0.resp_err !== 1'b0) begin fails++; $display("FAIL and_id_err got %b%b want 00", if0.resp_id, if0.resp_err); end
        tick();
        tests++; if (if0.resp_valid !== 1'b0) begin fails++; $display("FAIL and_drain got %b want 0", if0.resp_valid); end
    endtask

    task automatic test_contention();
        int ng, nr, viol;
        logic [3:0] gseq, rseq;
        logic [31:0] rres [4];
        logic busy;
        reset = 1'b1; tick(); reset = 1'b0;
        if0.req0_a = 32'hAAAAAAAA; if0.req0_b = 32'h55555555; if0.req0_op = 3'd4;
        if0.req1_a = 32'h0;        if0.req1_b = 32'h0;        if0.req1_op = 3'd3;
        if0.req0_valid = 1'b1; if0.req1_valid = 1'b1; if0.resp_ready = 1'b1;
        ng = 0; nr = 0; viol = 0; busy = 1'b0; gseq = '0; rseq = '0;
        for (int c = 0; c < 80 && nr < 4; c++) begin
            #1;
            if (busy && (if0.req0_ready || if0.req1_ready)) viol++;
            if (if0.req0_ready && if0.req1_ready) viol++;
            if ((if0.req0_ready || if0.req1_ready) && ng < 4) begin
                gseq[ng] = if0.req1_ready; ng++; busy = 1'b1;
            end
            if (if0.resp_valid && if0.resp_ready && nr < 4) begin
                rseq[nr] = if0.resp_id; rres[nr] = if0.resp_result; nr++; busy = 1'b0;
            end
            tick();
        end
        if0.req0_valid = 1'b0; if0.req1_valid = 1'b0;
        tests++; if (ng !== 4 || nr !== 4) begin fails++; $display("FAIL cont_count got %0d/%0d want 4/4", ng, nr); end
        tests++; if (gseq !== 4'b1010) begin fails++; $display("FAIL cont_grant_seq got %b want 1010 (lsb first)", gseq); end
        tests++; if (rseq !== 4'b1010) begin fails++; $display("FAIL cont_resp_ids got %b want 1010 (lsb first)", rseq); end
        tests++; if (rres[0] !== 32'hFFFFFFFF || rres[1] !== 32'hFFFFFFFF) begin fails++; $display("FAIL cont_results got %h %h want ffffffff ffffffff", rres[0], rres[1]); end
        tests++; if (viol !== 0) begin fails++; $display("FAIL cont_ready_busy got %0d want 0", viol); end
        tick(); tick();
    endtask

    task automatic test_backpressure();
        int n;
        logic [31:0] hres;
        reset = 1'b1; tick(); reset = 1'b0;
        if0.resp_ready = 1'b0;
        if0.req0_a = 32'h0000FFFF; if0.req0_b = 32'h00FF00FF; if0.req0_op = 3'd2;
        if0.req0_valid = 1'b1;
        tick();
        if0.req0_valid = 1'b0;
        n = 1;
        while (!if0.resp_valid && n < 20) begin tick(); n++; end
        tests++; if (if0.resp_valid !== 1'b1) begin fails++; $display("FAIL bp_resp_timeout got %b want 1", if0.resp_valid); end
        hres = 32'h00FFFFFF;
        if0.req0_valid = 1'b1; if0.req1_valid = 1'b1;
        if0.req1_a = 32'hF0F0F0F0; if0.req1_b = 32'hFF00FF00; if0.req1_op = 3'd4;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++; if (if0.resp_valid !== 1'b1 || if0.resp_result !== hres || if0.resp_id !== 1'b0) begin
                fails++; $display("FAIL bp_hold[%0d] got v=%b r=%h id=%b want 1 %h 0", i, if0.resp_valid, if0.resp_result, if0.resp_id, hres); end
            tests++; if ({if0.req0_ready, if0.req1_ready} !== 2'b00) begin fails++; $display("FAIL bp_no_grant[%0d] got %b want 00", i, {if0.req0_ready, if0.req1_ready}); end
        end
        if0.req0_valid = 1'b0;
        if0.resp_ready = 1'b1;
        tick();
        tests++; if (if0.resp_valid !== 1'b0) begin fails++; $display("FAIL bp_release got %b want 0", if0.resp_valid); end
        tests++; if (if0.req1_ready !== 1'b1) begin fails++; $display("FAIL bp_next_grant got %b want 1", if0.req1_ready); end
        tick();
        if0.req1_valid = 1'b0;
        n = 1;
        while (!if0.resp_valid && n < 20) begin tick(); n++; end
        tests++; if (if0.resp_result !== 32'h0FF00FF0 || if0.resp_id !== 1'b1) begin fails++; $display("FAIL bp_second got %h id=%b want 0ff00ff0 1", if0.resp_result, if0.resp_id); end
        tick();
    endtask

    task automatic test_reserved();
        int n;
        if0.resp_ready = 1'b1;
        if0.req1_a = 32'h12345678; if0.req1_b = 32'h12345678; if0.req1_op = 3'd6;
        if0.req1_valid = 1'b1;
        tick();
        if0.req1_valid = 1'b0;
        tests++; if (if0.lu_op !== 3'd6) begin fails++; $display("FAIL rsv_launch_op got %0d want 6", if0.lu_op); end
        n = 1;
        while (!if0.resp_valid && n < 20) begin tick(); n++; end
        tests++; if (if0.resp_err !== 1'b1) begin fails++; $display("FAIL rsv_err got %b want 1", if0.resp_err); end
        tests++; if (if0.resp_result !== 32'h0) begin fails++; $display("FAIL rsv_result got %h want 0", if0.resp_result); end
        tests++; if (if0.resp_id !== 1'b1) begin fails++; $display("FAIL rsv_id got %b want 1", if0.resp_id); end
`ifdef LU_ZERO_FLAG_EN
        tests++; if (if0.resp_zero !== 1'b1) begin fails++; $display("FAIL rsv_zero got %b want 1", if0.resp_zero); end
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        if0.resp_ready = 1'b1;
        if0.req0_a = 32'h89ABCDEF; if0.req0_b = 32'hFFFFFFFF; if0.req0_op = 3'd0;
        if0.req0_valid = 1'b1;
        tick();
        if0.req0_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (if0.lu_a !== 32'h0 || if0.lu_b !== 32'h0 || if0.lu_op !== 3'd0) begin
            fails++; $display("FAIL mid_lu_cleared got %h %h %0d want 0 0 0", if0.lu_a, if0.lu_b, if0.lu_op); end
        tests++; if (if0.resp_valid !== 1'b0 || if0.resp_result !== 32'h0 || if0.resp_id !== 1'b0 || if0.resp_err !== 1'b0) begin
            fails++; $display("FAIL mid_resp_cleared got v=%b r=%h id=%b e=%b want all 0", if0.resp_valid, if0.resp_result, if0.resp_id, if0.resp_err); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (if0.resp_valid) seen++; end
        tests++; if (seen !== 0) begin fails++; $display("FAIL mid_no_resp got %0d want 0", seen); end
        if0.req0_op = 3'd2; if0.req1_op = 3'd2;
        if0.req0_valid = 1'b1; if0.req1_valid = 1'b1;
        #1;
        tests++; if ({if0.req0_ready, if0.req1_ready} !== 2'b10) begin fails++; $display("FAIL mid_prio_reset got %b want 10", {if0.req0_ready, if0.req1_ready}); end
        tick();
        if0.req0_valid = 1'b0; if0.req1_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_settle_sweep();
        int n1, n15;
        ifs1.req0_a = 32'h00000001;  ifs1.req0_b = 32'h80000000;  ifs1.req0_op = 3'd2;
        ifs15.req0_a = 32'h00000001; ifs15.req0_b = 32'h80000000; ifs15.req0_op = 3'd2;
        ifs1.resp_ready = 1'b1; ifs15.resp_ready = 1'b1;
        ifs1.req0_valid = 1'b1; ifs15.req0_valid = 1'b1;
        #1;
        tests++; if (ifs1.req0_ready !== 1'b1 || ifs15.req0_ready !== 1'b1) begin fails++; $display("FAIL sweep_grant got %b%b want 11", ifs1.req0_ready, ifs15.req0_ready); end
        n1 = 0; n15 = 0;
        for (int c = 1; c <= 30 && (n1 == 0 || n15 == 0); c++) begin
            tick();
            ifs1.req0_valid = 1'b0; ifs15.req0_valid = 1'b0;
            if (ifs1.resp_valid && n1 == 0) begin
                n1 = c;
                tests++; if (ifs1.resp_result !== 32'h80000001) begin fails++; $display("FAIL sweep1_result got %h want 80000001", ifs1.resp_result); end
            end
            if (ifs15.resp_valid && n15 == 0) begin
                n15 = c;
                tests++; if (ifs15.resp_result !== 32'h80000001) begin fails++; $display("FAIL sweep15_result got %h want 80000001", ifs15.resp_result); end
            end
        end
        tests++; if (n1 !== 2) begin fails++; $display("FAIL sweep1_latency got %0d want 2", n1); end
        tests++; if (n15 !== 16) begin fails++; $display("FAIL sweep15_latency got %0d want 16", n15); end
    endtask

    initial begin
        if0.req0_valid = 1'b0; if0.req0_a = '0; if0.req0_b = '0; if0.req0_op = '0;
        if0.req1_valid = 1'b0; if0.req1_a = '0; if0.req1_b = '0; if0.req1_op = '0;
        if0.resp_ready = 1'b0;
        ifs1.req0_valid = 1'b0; ifs1.req0_a = '0; ifs1.req0_b = '0; ifs1.req0_op = '0;
        ifs1.req1_valid = 1'b0; ifs1.req1_a = '0; ifs1.req1_b = '0; ifs1.req1_op = '0;
        ifs1.resp_ready = 1'b0;
        ifs15.req0_valid = 1'b0; ifs15.req0_a = '0; ifs15.req0_b = '0; ifs15.req0_op = '0;
        ifs15.req1_valid = 1'b0; ifs15.req1_a = '0; ifs15.req1_b = '0; ifs15.req1_op = '0;
        ifs15.resp_ready = 1'b0;
        test_reset();
        test_single_and();
        test_contention();
        test_backpressure();
        test_reserved();
        test_reset_mid();
        test_settle_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 32-bit bitwise logic unit (AND/NAND/OR/NOR/XOR instances with gate delay) between two requesters.
- Handles per-request arbitration and operand launch.
- Waits a fixed settle time to cover gate propagation delay, then captures and returns the result.
- Sits between the ALU front-end issue ports and the shared logic datapath.
- Round-robin fairness; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand/result width.
- SETTLE_CYCLES, 2, clock cycles between operand launch and result capture; legal range 1 to 15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_op  input  3  requester 0 opcode.
- req1_valid  input  1  requester 1 has an operation.
- req1_ready  output  1  requester 1 operation accepted this cycle.
- req1_a  input  WIDTH  requester 1 operand A.
- req1_b  input  WIDTH  requester 1 operand B.
- req1_op  input  3  requester 1 opcode.
- lu_a  output  WIDTH  operand A driven to the logic unit.
- lu_b  output  WIDTH  operand B driven to the logic unit.
- lu_op  output  3  opcode driven to the logic unit (0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5-7 reserved).
- lu_result  input  WIDTH  logic unit output.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  1  requester that owns the result.
- resp_result  output  WIDTH  captured result.
- resp_err  output  1  opcode was reserved; result forced to 0.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, priority pointer=0.
  - lu_a, lu_b, lu_op = 0.
  - resp_valid, resp_id, resp_result, resp_err = 0.
  - Settle counter = 0.
- States: IDLE, SETTLE, RESP.
- IDLE:
  - reqN_ready is combinational and asserts only in IDLE, for the granted requester only.
  - Grant rule: if exactly one valid, grant it; if both valid, grant the priority pointer's requester.
  - On grant (valid & ready), the same edge:
    - registers operands/opcode onto lu_a/lu_b/lu_op;
    - records resp_id;
    - sets counter = SETTLE_CYCLES-1;
    - moves to SETTLE;
    - flips priority pointer to the other requester.
  - A reserved opcode is still launched; its error is recorded for resp_err.
- SETTLE:
  - Counter decrements each cycle.
  - In the cycle counter==0: capture lu_result into resp_result (0 if reserved op), set resp_valid=1, move to RESP.
  - Launch-to-resp_valid latency is exactly SETTLE_CYCLES+1 cycles.
- RESP:
  - resp_valid, resp_id, resp_result, resp_err are held stable until resp_ready.
  - On resp_valid & resp_ready: clear resp_valid, go to IDLE.
  - Next grant is possible the following cycle.
  - Minimum issue interval: SETTLE_CYCLES+3 cycles.
- lu_a/lu_b/lu_op remain stable from launch until the next grant; they are not zeroed between operations.
- A requester dropping valid while not granted: no effect. Valid is not required to stay high after grant.
- resp_ready asserted while not in RESP: ignored.
- Reset mid-operation (SETTLE or RESP): the in-flight operation is discarded, no response is issued, and all reset values are restored next cycle.
- Priority pointer changes only on grant, never on response.

Optional Feature:
- Macro: LU_ZERO_FLAG_EN.
- With the macro defined:
  - adds output resp_zero (1 bit), registered with resp_result;
  - resp_zero = 1 when the captured result is all zeros (including the forced-zero error case);
  - reset value of resp_zero = 0.
- Without the macro: port absent; no other behaviour changes.

Test Plan:
- Single AND: reset, then req0 a=0xFFFF0000 b=0x0F0F0F0F op=0 with resp_ready=1.
  - Expect resp_valid exactly 3 cycles after grant (SETTLE_CYCLES=2).
  - Expect resp_result=0x0F0F0000, resp_id=0, resp_err=0.
- Contention: both requesters valid continuously; req0 XOR 0xAAAAAAAA^0x55555555, req1 NOR 0^0.
  - Expect grants alternating 0,1,0,1.
  - Expect results 0xFFFFFFFF (id 0) and 0xFFFFFFFF (id 1).
  - Expect reqN_ready never high in SETTLE/RESP.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid.
  - Expect resp_result, resp_id, resp_valid stable and no new grant.
  - Release resp_ready; expect the next grant the cycle after the handshake.
- Reserved opcode: req1 op=6, a=b=0x12345678.
  - Expect resp_err=1, resp_result=0, resp_id=1.
  - With LU_ZERO_FLAG_EN, expect resp_zero=1.
- Reset mid-SETTLE: assert reset for 1 cycle during SETTLE.
  - Expect no resp_valid.
  - Expect all outputs 0 and priority pointer 0, so req0 wins the first subsequent contention.
- Settle sweep: SETTLE_CYCLES=1 and 15; OR 0x00000001|0x80000000.
  - Expect latency 2 and 16 cycles respectively, with result 0x80000001.
